csm_access_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the CSM shared register file.

---
 rtl/csm_access_arbiter_if.sv | 43 ++++
 rtl/csm_access_arbiter.sv | 173 +++++++++++++++++
 tb/tb_csm_access_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/csm_access_arbiter_if.sv
// Processor-facing bundle for the CSM access arbiter: the A and B command/response
// ports plus the shared lock-owner and busy status.
interface csm_access_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic [1:0]        a_op;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_done;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic [1:0]        b_op;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic [1:0]        owner;
  logic              busy;

  // Processors (or the bfm) issue commands and observe responses.
  modport master (
    output a_req, a_op, a_addr, a_wdata,
    input  a_done, a_err, a_rdata,
    output b_req, b_op, b_addr, b_wdata,
    input  b_done, b_err, b_rdata,
    input  owner, busy
  );

  // The arbiter accepts commands and drives responses.
  modport slave (
    input  a_req, a_op, a_addr, a_wdata,
    output a_done, a_err, a_rdata,
    input  b_req, b_op, b_addr, b_wdata,
    output b_done, b_err, b_rdata,
    output owner, busy
  );
endinterface

// File: rtl/csm_access_arbiter.sv
// Two-requester arbiter/sequencer for the CSM shared register file. Owns the array,
// serialises A/B commands through IDLE -> ACCESS -> RESP and enforces the hold lock.
module csm_access_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csm_access_arbiter_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_HOLD    = 2'b10,
    OP_RELEASE = 2'b11
  } op_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_t            state, state_nxt;

  // Grant decision made in IDLE
  logic              grant_valid;
  logic              grant_b;
  logic              rr_flip;

  // Latched command
  logic              sel_b;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Persistent arbitration / lock state and registered response
  logic              rr_b;
  logic [1:0]        owner_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Execution results computed in ACCESS
  logic [1:0]        self_code;
  logic [1:0]        other_code;
  logic              foreign_lock;
  logic [1:0]        owner_nxt;
  logic              err_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_b     = 1'b0;
    rr_flip     = 1'b0;
    case (state)
      S_IDLE: begin
        grant_valid = bus.a_req | bus.b_req;
        if (bus.a_req && bus.b_req) begin
          // The lock owner beats round-robin; the pointer only moves on a true tie.
          if (owner_q == OWN_A)      grant_b = 1'b0;
          else if (owner_q == OWN_B) grant_b = 1'b1;
          else begin
            grant_b = rr_b;
            rr_flip = 1'b1;
          end
        end else begin
          grant_b = bus.b_req;
        end
        if (grant_valid) state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign self_code    = sel_b ? OWN_B : OWN_A;
  assign other_code   = sel_b ? OWN_A : OWN_B;
  assign foreign_lock = (owner_q == other_code);

  always_comb begin
    owner_nxt = owner_q;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    mem_we    = 1'b0;
    case (op_q)
      OP_READ: begin
        if (foreign_lock) err_nxt   = 1'b1;
        else              rdata_nxt = mem[addr_q];
      end
      OP_WRITE: begin
        if (foreign_lock) err_nxt = 1'b1;
        else              mem_we  = 1'b1;
      end
      OP_HOLD: begin
        // A repeat hold by the owner re-asserts the same owner: accepted, no effect.
        if (foreign_lock) err_nxt   = 1'b1;
        else              owner_nxt = self_code;
      end
      OP_RELEASE: begin
        if (owner_q == self_code) owner_nxt = OWN_NONE;
        else                      err_nxt   = 1'b1;
      end
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_b   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rr_b    <= 1'b0;
      owner_q <= OWN_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && grant_valid) begin
        sel_b   <= grant_b;
        op_q    <= op_t'(grant_b ? bus.b_op : bus.a_op);
        addr_q  <= grant_b ? bus.b_addr  : bus.a_addr;
        wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
        if (rr_flip) rr_b <= ~rr_b;
      end
      if (state == S_ACCESS) begin
        owner_q <= owner_nxt;
        err_q   <= err_nxt;
        rdata_q <= rdata_nxt;
      end
    end
  end

  // NOTE: the array is cleared by reset because its contents are architecturally
  // visible after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_ACCESS && mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Response fields are forced to zero outside the single done cycle.
  assign bus.a_done  = (state == S_RESP) && !sel_b;
  assign bus.b_done  = (state == S_RESP) &&  sel_b;
  assign bus.a_err   = bus.a_done & err_q;
  assign bus.b_err   = bus.b_done & err_q;
  assign bus.a_rdata = bus.a_done ? rdata_q : '0;
  assign bus.b_rdata = bus.b_done ? rdata_q : '0;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_csm_access_arbiter.sv
// Directed bench for csm_access_arbiter: single and contended commands, lock rules,
// round-robin order and mid-command reset, against hand-computed expectations.
module tb_csm_access_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_HLD = 2'b10;
  localparam logic [1:0] OP_REL = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  csm_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  csm_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one command on a single port, wait (bounded) for done, drop req when seen.
  task automatic cmd(input bit on_b, input logic [1:0] op, input logic [1:0] addr,
                     input logic [7:0] wdata, output logic [7:0] rdata,
                     output logic err, output int lat, output bit seen);
    @(negedge clk);
    if (on_b) begin
      bus.b_req = 1'b1; bus.b_op = op; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_op = op; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    lat = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (on_b ? bus.b_done : bus.a_done) begin
        seen  = 1'b1;
        rdata = on_b ? bus.b_rdata : bus.a_rdata;
        err   = on_b ? bus.b_err   : bus.a_err;
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  // Run one command and check done latency, err and rdata.
  task automatic run(input string tag, input bit on_b, input logic [1:0] op,
                     input logic [1:0] addr, input logic [7:0] wdata,
                     input logic exp_err, input logic [7:0] exp_rdata);
    logic [7:0] rd;
    logic       er;
    int         lat;
    bit         seen;
    cmd(on_b, op, addr, wdata, rd, er, lat, seen);
    check({tag, ".done"},  {31'b0, seen}, 32'd1);
    check({tag, ".lat"},   lat,           32'd2);
    check({tag, ".err"},   {31'b0, er},   {31'b0, exp_err});
    check({tag, ".rdata"}, {24'b0, rd},   {24'b0, exp_rdata});
  endtask

  // Raise both requests together; each port drops its req when it sees its done.
  task automatic both(input string tag, input logic [1:0] op_a, input logic [1:0] op_b,
                      input logic [1:0] addr, input bit exp_b_first,
                      input logic exp_a_err, input logic exp_b_err,
                      input logic [7:0] exp_a_rd, input logic [7:0] exp_b_rd);
    bit         a_seen = 1'b0, b_seen = 1'b0, b_first = 1'b0;
    logic       a_er = 1'b0, b_er = 1'b0;
    logic [7:0] a_rd = '0, b_rd = '0;
    int         cyc = 0;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_op = op_a; bus.a_addr = addr; bus.a_wdata = 8'h00;
    bus.b_req = 1'b1; bus.b_op = op_b; bus.b_addr = addr; bus.b_wdata = 8'h00;
    while (!(a_seen && b_seen) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.a_done) begin
        a_seen = 1'b1; b_first = b_seen; a_er = bus.a_err; a_rd = bus.a_rdata; bus.a_req = 1'b0;
      end
      if (bus.b_done) begin
        b_seen = 1'b1; b_er = bus.b_err; b_rd = bus.b_rdata; bus.b_req = 1'b0;
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    check({tag, ".both_done"}, {30'b0, a_seen, b_seen},  32'd3);
    check({tag, ".b_first"},   {31'b0, b_first},         {31'b0, exp_b_first});
    check({tag, ".a_err"},     {31'b0, a_er},            {31'b0, exp_a_err});
    check({tag, ".b_err"},     {31'b0, b_er},            {31'b0, exp_b_err});
    check({tag, ".a_rdata"},   {24'b0, a_rd},            {24'b0, exp_a_rd});
    check({tag, ".b_rdata"},   {24'b0, b_rd},            {24'b0, exp_b_rd});
  endtask

  initial begin
    bit any_done;

    bus.a_req = 1'b0; bus.a_op = '0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_op = '0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy",    {31'b0, bus.busy},   32'd0);
    check("rst.owner",   {30'b0, bus.owner},  32'd0);
    check("rst.done",    {30'b0, bus.a_done, bus.b_done}, 32'd0);
    check("rst.rdata",   {16'b0, bus.a_rdata, bus.b_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write then read back through A
    run("t1.wr", 1'b0, OP_WR, 2'd2, 8'hA5, 1'b0, 8'h00);
    run("t1.rd", 1'b0, OP_RD, 2'd2, 8'h00, 1'b0, 8'hA5);
    @(negedge clk);
    check("t1.idle_rdata", {24'b0, bus.a_rdata}, 32'd0);
    check("t1.idle_busy",  {31'b0, bus.busy},    32'd0);

    // 2: round-robin on a tie with no owner: A first, then B first
    both("t2.rr0", OP_RD, OP_RD, 2'd2, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    both("t2.rr1", OP_RD, OP_RD, 2'd2, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5);

    // 3: A holds; B blocked from read and write
    run("t3.a_hold", 1'b0, OP_HLD, 2'd0, 8'h00, 1'b0, 8'h00);
    check("t3.owner_a", {30'b0, bus.owner}, 32'd1);
    run("t3.b_rd",   1'b1, OP_RD, 2'd0, 8'h00, 1'b1, 8'h00);
    run("t3.b_wr",   1'b1, OP_WR, 2'd0, 8'hFF, 1'b1, 8'h00);
    run("t3.a_rd",   1'b0, OP_RD, 2'd0, 8'h00, 1'b0, 8'h00);
    run("t3.a_rehold", 1'b0, OP_HLD, 2'd0, 8'h00, 1'b0, 8'h00);
    check("t3.owner_still_a", {30'b0, bus.owner}, 32'd1);
    run("t3.a_rel",  1'b0, OP_REL, 2'd0, 8'h00, 1'b0, 8'h00);

    // 4: hold/release cycle, then releases with no owner are rejected
    run("t4.a_hold", 1'b0, OP_HLD, 2'd0, 8'h00, 1'b0, 8'h00);
    run("t4.a_rel",  1'b0, OP_REL, 2'd0, 8'h00, 1'b0, 8'h00);
    check("t4.owner_none", {30'b0, bus.owner}, 32'd0);
    run("t4.b_rd",   1'b1, OP_RD, 2'd1, 8'h00, 1'b0, 8'h00);
    run("t4.b_rel",  1'b1, OP_REL, 2'd0, 8'h00, 1'b1, 8'h00);

    // 5: simultaneous hold (pointer at A) -> A owns; owner then wins every tie
    both("t5.hold", OP_HLD, OP_HLD, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    check("t5.owner_a", {30'b0, bus.owner}, 32'd1);
    both("t5.own0", OP_RD, OP_RD, 2'd2, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00);
    both("t5.own1", OP_RD, OP_RD, 2'd2, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00);
    run("t5.b_rel",  1'b1, OP_REL, 2'd0, 8'h00, 1'b1, 8'h00);
    run("t5.a_wr",   1'b0, OP_WR,  2'd1, 8'h77, 1'b0, 8'h00);
    run("t5.a_rd",   1'b0, OP_RD,  2'd1, 8'h00, 1'b0, 8'h77);
    check("t5.owner_kept", {30'b0, bus.owner}, 32'd1);

    // 6: reset mid-command while A holds the lock
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_op = OP_RD; bus.a_addr = 2'd1; bus.a_wdata = 8'h00;
    @(negedge clk);
    check("t6.busy_access", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6.rst_busy",  {31'b0, bus.busy},  32'd0);
    check("t6.rst_owner", {30'b0, bus.owner}, 32'd0);
    bus.a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.a_done || bus.b_done) any_done = 1'b1;
    end
    check("t6.no_done", {31'b0, any_done}, 32'd0);
    run("t6.rd1", 1'b0, OP_RD, 2'd1, 8'h00, 1'b0, 8'h00);
    run("t6.rd2", 1'b1, OP_RD, 2'd2, 8'h00, 1'b0, 8'h00);
    check("t6.owner_none", {30'b0, bus.owner}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
